// File: rtl/sram_bridge_pkg.sv
// Shared defaults, macro tie-off constants and the byte-enable to active-low bit-mask helper
// for the SRAM bus bridge.
package sram_bridge_pkg;

    localparam int          ADDR_W_DFLT    = 13;
    localparam int          SRAM_AW_DFLT   = 10;
    localparam int          RSP_DEPTH_DFLT = 2;
    localparam logic [2:0]  WTSEL_DFLT     = 3'b001;
    localparam logic [1:0]  RTSEL_DFLT     = 2'b01;

    // Active-low 64-bit write mask: the selected 32-bit lane follows be, the other lane is masked off.
    function automatic logic [63:0] be_to_bweb(input logic [3:0] be, input logic lane);
        logic [31:0] m;
        m = '1;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{~be[i]}};
        end
        return lane ? {m, 32'hFFFF_FFFF} : {32'hFFFF_FFFF, m};
    endfunction

endpackage

// File: rtl/sram_bridge_rsp_fifo.sv
// Purpose: 2-entry first-word-fall-through FIFO of 32-bit read responses with occupancy count.
// Latency: 0 cycles when empty (push bypasses straight to the output), else head of queue.
// Backpressure: holds data while out_rdy=0; upstream credits guarantee no push when full.
module sram_bridge_rsp_fifo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_vld,
    input  logic [31:0] push_dat,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [31:0] out_dat,
    output logic [1:0]  count
);

    logic [31:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        empty;
    logic        pop;
    logic        bypass;
    logic        wr_en;
    logic        rd_en;

    assign empty   = (count == 2'd0);
    assign out_vld = rst_n & (~empty | push_vld);
    assign out_dat = ~out_vld ? 32'd0 : (empty ? push_dat : mem[rd_ptr]);
    assign pop     = out_vld & out_rdy;
    // A push consumed in the same cycle it arrives into an empty FIFO never touches storage.
    assign bypass  = empty & push_vld & pop;
    assign wr_en   = push_vld & ~bypass;
    assign rd_en   = pop & ~empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rd_en) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push_vld} - {1'b0, pop};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_vld && count == 2'd2));

endmodule

// File: rtl/sram_bus_bridge.sv
// Purpose: 32-bit valid/ready bus onto a 1024x64 single-port SRAM (8 KiB); SRAM_BRIDGE_PERF_EN adds perf counters.
// Latency: read data presented the cycle after acceptance; writes complete at the accepting edge, no response.
// Backpressure: reads credit-limited by FIFO occupancy plus in-flight read; writes always accepted.
module sram_bus_bridge
    import sram_bridge_pkg::*;
#(
    parameter int         ADDR_W    = ADDR_W_DFLT,
    parameter int         SRAM_AW   = SRAM_AW_DFLT,
    parameter int         RSP_DEPTH = RSP_DEPTH_DFLT,
    parameter logic [2:0] WTSEL_VAL = WTSEL_DFLT,
    parameter logic [1:0] RTSEL_VAL = RTSEL_DFLT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [3:0]         req_be,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_rdata,
    output logic               sram_ceb,
    output logic               sram_web,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [63:0]        sram_d,
    output logic [63:0]        sram_bweb,
    output logic [2:0]         sram_wtsel,
    output logic [1:0]         sram_rtsel,
    input  logic [63:0]        sram_q
`ifdef SRAM_BRIDGE_PERF_EN
    ,
    output logic [31:0]        perf_rd_cnt,
    output logic [31:0]        perf_wr_cnt
`endif
);

    localparam logic [2:0] CREDITS = 3'(RSP_DEPTH);

    logic        fire;
    logic        rd_fire;
    logic        wr_fire;
    logic        lane;
    logic        credit_ok;
    logic        rd_inflight;
    logic        rd_lane;
    logic        push_vld;
    logic [31:0] push_dat;
    logic [1:0]  fifo_cnt;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];

    assign credit_ok = ({1'b0, fifo_cnt} + {2'b00, rd_inflight}) < CREDITS;
    assign req_ready = rst_n & (req_we | credit_ok);
    assign fire      = req_valid & req_ready;
    assign rd_fire   = fire & ~req_we;
    assign wr_fire   = fire & req_we;
    assign lane      = req_addr[2];

    // Macro controls are idle (deselected, zero address/data, fully masked) unless a request fires.
    assign sram_ceb   = ~fire;
    assign sram_web   = ~wr_fire;
    assign sram_a     = fire ? req_addr[ADDR_W-1:3] : '0;
    assign sram_d     = fire ? {req_wdata, req_wdata} : 64'd0;
    assign sram_bweb  = wr_fire ? be_to_bweb(req_be, lane) : '1;
    assign sram_wtsel = WTSEL_VAL;
    assign sram_rtsel = RTSEL_VAL;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_inflight <= 1'b0;
            rd_lane     <= 1'b0;
        end else begin
            rd_inflight <= rd_fire;
            if (rd_fire) begin
                rd_lane <= lane;
            end
        end
    end

    // Q is valid the cycle after the read; a read caught by reset is dropped here.
    assign push_vld = rd_inflight & rst_n;
    assign push_dat = rd_lane ? sram_q[63:32] : sram_q[31:0];

    sram_bridge_rsp_fifo u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .out_vld  (rsp_valid),
        .out_rdy  (rsp_ready),
        .out_dat  (rsp_rdata),
        .count    (fifo_cnt)
    );

`ifdef SRAM_BRIDGE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_rd_cnt <= 32'd0;
            perf_wr_cnt <= 32'd0;
        end else begin
            if (rd_fire) begin
                perf_rd_cnt <= perf_rd_cnt + 32'd1;
            end
            if (wr_fire) begin
                perf_wr_cnt <= perf_wr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/sram_bus_bridge.md
Name: sram_bus_bridge

Overview:
- Adapts the core's 32-bit valid/ready memory bus onto one 1024x64 single-port synchronous SRAM macro, making an 8 KiB memory.
- Sits directly upstream of the macro and drives its active-low CEB/WEB/BWEB controls, address and write data.
- Captures the macro's Q one cycle after each read and returns the selected 32-bit half through a 2-entry response FIFO, so it tolerates response back-pressure.

Parameters:
- ADDR_W, 13, byte-address width (2^13 = 8 KiB).
- SRAM_AW, 10, macro word-address width.
- RSP_DEPTH, 2, response FIFO depth; fixed at 2, other values unsupported.
- WTSEL_VAL, 3'b001, constant driven on sram_wtsel.
- RTSEL_VAL, 2'b01, constant driven on sram_rtsel.

Ports:
- clk  in  1  rising-edge clock; bridge and macro share it.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  bridge accepts the request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables (writes only).
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  read data.
- sram_ceb  out  1  macro chip enable, active low.
- sram_web  out  1  macro write enable, active low.
- sram_a  out  SRAM_AW  macro word address.
- sram_d  out  64  macro write data.
- sram_bweb  out  64  macro bit-write enable, active low.
- sram_wtsel  out  3  tie-off WTSEL_VAL.
- sram_rtsel  out  2  tie-off RTSEL_VAL.
- sram_q  in  64  macro read data.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values: req_ready=0 while rst_n=0; rsp_valid=0; rsp_rdata=0; sram_ceb=1; sram_web=1; sram_bweb=all 1s; sram_a=0; sram_d=0.
- Accept: fire = req_valid & req_ready.
  - req_ready = (fifo_count + rd_inflight) < 2.
  - Writes ignore the credit check: req_ready=1 for writes whenever out of reset.
- Macro drive (combinational from req_*, qualified by fire):
  - sram_ceb = ~fire.
  - sram_web = ~req_we.
  - sram_a = req_addr[12:3].
  - sram_d = {req_wdata, req_wdata}.
- Lane select: lane = req_addr[2].
  - lane 0 → sram_bweb[31:0] = ~(bit-expanded req_be); sram_bweb[63:32] = all 1s.
  - lane 1 → the mirror: upper half from req_be, lower half all 1s.
  - Write with req_be=0: CEB still asserted, BWEB all 1s, so the array is unchanged.
- Writes produce no response.
- Read pipeline:
  - Cycle N: read fires; rd_inflight<=1 and rd_lane<=lane are registered.
  - Cycle N+1: sram_q is valid. The bridge pushes sram_q[32*rd_lane +: 32] into the FIFO and clears rd_inflight.
  - If a second read fires in N+1, rd_inflight stays 1.
  - Earliest rsp_valid is cycle N+1 relative to acceptance: the FIFO is first-word-fall-through, so the push is visible the same cycle through a bypass mux when the FIFO is empty.
  - Sustained throughput is one read per cycle when rsp_ready=1.
- Order: responses are returned in request order. A read after a write to the same address in the next cycle returns the new data (macro write completes at that edge).
- FIFO:
  - Push and pop in the same cycle keep the count unchanged.
  - The credit rule makes overflow impossible; a push at count==2 is a design error and fires an assertion.
  - Pop happens on rsp_valid & rsp_ready.
- Reset mid-operation: the in-flight read is dropped, the FIFO is flushed, no response is emitted, and array contents are untouched.

Optional Feature:
- SRAM_BRIDGE_PERF_EN defined: adds outputs perf_rd_cnt[31:0] and perf_wr_cnt[31:0].
  - Each increments on an accepted read / accepted write respectively.
  - Both wrap at 2^32, reset to 0, and are never incremented by back-pressured cycles.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package sram_bridge_pkg: ADDR_W/SRAM_AW defaults, WTSEL/RTSEL tie-off constants, function be_to_bweb(be, lane) returning the 64-bit active-low mask.
- One sub-module, sram_bridge_rsp_fifo: 2-entry FWFT FIFO of 32-bit words with count output.

Test Plan:
- Write addr 0x0004, wdata 0xDEADBEEF, be 4'hF, then read 0x0004 → sram_bweb = 0x00000000_FFFFFFFF; rsp_rdata = 0xDEADBEEF exactly 1 cycle after read acceptance.
- Write 0x0000 = 0x11223344, then write 0x0000 data 0xAABBCCDD be 4'b0101 → read 0x0000 returns 0x11BB33DD; the upper lane at 0x0004 is unchanged.
- Back-to-back reads 0x10, 0x14, 0x18 with rsp_ready=0 → req_ready drops after 2 accepted reads; releasing rsp_ready returns the three words in order with no loss.
- Continuous reads with rsp_ready=1 for 16 cycles → 16 responses, req_ready held 1, sram_ceb low every cycle.
- Read fires, then rst_n=0 the next cycle → rsp_valid stays 0, sram_ceb=1; after reset, reading the same address returns the pre-reset written value.
- With SRAM_BRIDGE_PERF_EN: 5 writes + 3 reads, including 2 back-pressured cycles → perf_wr_cnt=5, perf_rd_cnt=3.
